// File: rtl/usb_fifo_pkg.sv
// Shared definitions for the USB hub packet/byte FIFO slice.
package usb_fifo_pkg;

  localparam int DEF_WIDTH = 32'd8;
  localparam int DEF_DEPTH = 32'd16;

  // Read-mode encodings for the FWFT parameter
  localparam int FIFO_STD  = 32'd0;
  localparam int FIFO_FWFT = 32'd1;

  // Ceiling log2, usable in constant expressions (clog2(1) = 0)
  function automatic int clog2(input int value);
    int result;
    result = 32'd0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) begin
        result = i + 32'd1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// Handshake/status bundle between the FIFO owner (master) and the FIFO (slave).
interface sync_fifo_ctrl_if #(
  parameter int WIDTH = usb_fifo_pkg::DEF_WIDTH,
  parameter int DEPTH = usb_fifo_pkg::DEF_DEPTH
);
  import usb_fifo_pkg::*;

  localparam int AW = clog2(DEPTH);

  logic             flush;
  logic             wr_en;
  logic [WIDTH-1:0] w_data;
  logic             rd_en;
  logic             clr_err;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             flag_full;
  logic             flag_empty;
  logic             almost_full;
  logic             almost_empty;
  logic [AW:0]      level;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, wr_en, w_data, rd_en, clr_err,
    input  r_data, r_valid, flag_full, flag_empty, almost_full, almost_empty,
           level, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, w_data, rd_en, clr_err,
    output r_data, r_valid, flag_full, flag_empty, almost_full, almost_empty,
           level, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem
  import usb_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = clog2(DEPTH)
)(
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Capture accepted write data; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Synchronous FIFO controller: pointers, occupancy, flags, read mode and sticky errors.
module sync_fifo_ctrl
  import usb_fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = 32'd12,
  parameter int AE_THRESH = 32'd2,
  parameter int FWFT      = FIFO_STD
)(
  input logic             clk,
  input logic             rst_n,
  sync_fifo_ctrl_if.slave bus
);

  localparam int AW = clog2(DEPTH);

  localparam logic [AW:0]   LVL_ZERO = (AW+1)'(32'd0);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(32'd1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_AF   = (AW+1)'(AF_THRESH);
  localparam logic [AW:0]   LVL_AE   = (AW+1)'(AE_THRESH);
  localparam logic [AW-1:0] PTR_ZERO = AW'(32'd0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(32'd1);

  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      level_r;
  logic             overflow_r;
  logic             underflow_r;

  logic             full_s;
  logic             empty_s;
  logic             rd_acc_s;
  logic             wr_acc_s;
  logic             mem_we_s;
  logic             ovf_set_s;
  logic             udf_set_s;
  logic [WIDTH-1:0] head_s;

  // Flags decode only the registered level, so they cannot glitch
  assign full_s  = (level_r == LVL_FULL);
  assign empty_s = (level_r == LVL_ZERO);

  // Accept/reject decisions; flush suppresses storage writes and error capture
  always_comb begin
    rd_acc_s  = bus.rd_en & ~empty_s;
    wr_acc_s  = bus.wr_en & (~full_s | rd_acc_s);
    mem_we_s  = wr_acc_s & ~bus.flush;
    ovf_set_s = bus.wr_en & ~wr_acc_s & ~bus.flush;
    udf_set_s = bus.rd_en & empty_s & ~bus.flush;
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we_s),
    .waddr (wr_ptr_r),
    .wdata (bus.w_data),
    .raddr (rd_ptr_r),
    .rdata (head_s)
  );

  // Pointer and occupancy bookkeeping; flush outranks any same-cycle request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      level_r  <= LVL_ZERO;
    end else if (bus.flush) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      level_r  <= LVL_ZERO;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

  // Sticky error flags; a new error in the clearing cycle wins over clr_err
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= ovf_set_s | (overflow_r  & ~bus.clr_err);
      underflow_r <= udf_set_s | (underflow_r & ~bus.clr_err);
    end
  end

  generate
    if (FWFT == FIFO_FWFT) begin : g_fwft
      // Head entry shown directly; blanked while empty so reset reads as zero
      assign bus.r_data  = empty_s ? {WIDTH{1'b0}} : head_s;
      assign bus.r_valid = ~empty_s;
    end else begin : g_std
      logic [WIDTH-1:0] r_data_r;
      logic             r_valid_r;

      // Registered pop: data lands one cycle after rd_en, valid pulses once
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_data_r  <= {WIDTH{1'b0}};
          r_valid_r <= 1'b0;
        end else if (bus.flush) begin
          r_data_r  <= r_data_r;
          r_valid_r <= 1'b0;
        end else if (rd_acc_s) begin
          r_data_r  <= head_s;
          r_valid_r <= 1'b1;
        end else begin
          r_data_r  <= r_data_r;
          r_valid_r <= 1'b0;
        end
      end

      assign bus.r_data  = r_data_r;
      assign bus.r_valid = r_valid_r;
    end
  endgenerate

  assign bus.flag_full    = full_s;
  assign bus.flag_empty   = empty_s;
  assign bus.almost_full  = (level_r >= LVL_AF);
  assign bus.almost_empty = (level_r <= LVL_AE);
  assign bus.level        = level_r;
  assign bus.overflow     = overflow_r;
  assign bus.underflow    = underflow_r;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench: one standard-mode and one FWFT instance share the same stimulus.
module tb_sync_fifo_ctrl;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AF = 12;
  localparam int AE = 2;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       wr_en;
  logic [7:0] w_data;
  logic       rd_en;
  logic       clr_err;

  int n_checks;
  int n_fail;
  int cyc;

  // Reference model state: contents as a queue plus observable registers
  logic [7:0] q[$];
  logic       m_ovf;
  logic       m_udf;
  logic       m_std_rv;
  logic [7:0] m_std_rd;

  sync_fifo_ctrl_if #(.WIDTH(W), .DEPTH(D)) if_std ();
  sync_fifo_ctrl_if #(.WIDTH(W), .DEPTH(D)) if_fw ();

  assign if_std.flush   = flush;
  assign if_std.wr_en   = wr_en;
  assign if_std.w_data  = w_data;
  assign if_std.rd_en   = rd_en;
  assign if_std.clr_err = clr_err;
  assign if_fw.flush    = flush;
  assign if_fw.wr_en    = wr_en;
  assign if_fw.w_data   = w_data;
  assign if_fw.rd_en    = rd_en;
  assign if_fw.clr_err  = clr_err;

  sync_fifo_ctrl #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) u_std (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_std)
  );

  sync_fifo_ctrl #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) u_fw (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_fw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       flush;
    logic       wr;
    logic [7:0] wd;
    logic       rd;
    logic       clr;
    int         lvl;
    logic       empty;
    logic       udf;
    logic       std_rv;
    logic [7:0] std_rd;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input logic f, input logic w, input logic [7:0] wd,
                       input logic r, input logic c);
    flush = f; wr_en = w; w_data = wd; rd_en = r; clr_err = c;
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0; m_udf = 1'b0; m_std_rv = 1'b0; m_std_rd = 8'h00;
  endtask

  // Apply FIFO rules to the inputs present at this clock edge
  task automatic model_edge();
    int   sz;
    logic rd_a, wr_a, ovf_set, udf_set;
    sz = q.size();
    ovf_set = 1'b0;
    udf_set = 1'b0;
    if (flush) begin
      q.delete();
      m_std_rv = 1'b0;
    end else begin
      rd_a    = rd_en && (sz > 0);
      wr_a    = wr_en && ((sz < D) || rd_a);
      ovf_set = wr_en && !wr_a;
      udf_set = rd_en && (sz == 0);
      if (rd_a) begin
        m_std_rd = q.pop_front();
        m_std_rv = 1'b1;
      end else begin
        m_std_rv = 1'b0;
      end
      if (wr_a) q.push_back(w_data);
    end
    m_ovf = ovf_set ? 1'b1 : (clr_err ? 1'b0 : m_ovf);
    m_udf = udf_set ? 1'b1 : (clr_err ? 1'b0 : m_udf);
  endtask

  task automatic check_all();
    int sz;
    sz = q.size();
    chk("std.level",        if_std.level,        sz);
    chk("fw.level",         if_fw.level,         sz);
    chk("std.flag_full",    if_std.flag_full,    sz == D);
    chk("fw.flag_full",     if_fw.flag_full,     sz == D);
    chk("std.flag_empty",   if_std.flag_empty,   sz == 0);
    chk("fw.flag_empty",    if_fw.flag_empty,    sz == 0);
    chk("std.almost_full",  if_std.almost_full,  sz >= AF);
    chk("fw.almost_full",   if_fw.almost_full,   sz >= AF);
    chk("std.almost_empty", if_std.almost_empty, sz <= AE);
    chk("fw.almost_empty",  if_fw.almost_empty,  sz <= AE);
    chk("std.overflow",     if_std.overflow,     m_ovf);
    chk("fw.overflow",      if_fw.overflow,      m_ovf);
    chk("std.underflow",    if_std.underflow,    m_udf);
    chk("fw.underflow",     if_fw.underflow,     m_udf);
    chk("std.r_valid",      if_std.r_valid,      m_std_rv);
    chk("std.r_data",       if_std.r_data,       m_std_rd);
    chk("fw.r_valid",       if_fw.r_valid,       sz > 0);
    chk("fw.r_data",        if_fw.r_data,        (sz > 0) ? q[0] : 8'h00);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check_all();
  endtask

  // Async reset asserted between edges; outputs must react without a clock
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    model_reset();
    #1 rst_n = 1'b0;
    #2 check_all();
    #3 rst_n = 1'b1;

    // ---- Table-driven vectors from reset ----
    vecs[0]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b1, 8'h11};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b1, 8'h22};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1, 8'h33};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0, 8'h33};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'h33};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b1, 1'b1, 1'b0, 8'h33};
    vecs[8]  = '{1'b1, 1'b1, 8'h44, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 8'h33};
    vecs[9]  = '{1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b0, 8'h33};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 8'h33};
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].flush, vecs[i].wr, vecs[i].wd, vecs[i].rd, vecs[i].clr);
      step();
      chk("vec.level",     if_std.level,      vecs[i].lvl);
      chk("vec.empty",     if_std.flag_empty, vecs[i].empty);
      chk("vec.underflow", if_std.underflow,  vecs[i].udf);
      chk("vec.r_valid",   if_std.r_valid,    vecs[i].std_rv);
      chk("vec.r_data",    if_std.r_data,     vecs[i].std_rd);
    end

    // ---- Fill to full, almost_full threshold, overflow on 17th write ----
    async_reset();
    for (int i = 1; i <= D; i++) begin
      drive(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
      step();
      if (i == AF - 1) chk("fill.af_below", if_std.almost_full, 1'b0);
      if (i == AF)     chk("fill.af_at",    if_std.almost_full, 1'b1);
    end
    chk("fill.full",  if_std.flag_full, 1'b1);
    chk("fill.level", if_std.level,     D);
    drive(1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
    step();
    chk("fill.ovf_level", if_std.level,    D);
    chk("fill.ovf",       if_std.overflow, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    step();
    chk("fill.ovf_clr", if_std.overflow, 1'b0);

    // ---- Full with simultaneous read/write across pointer wrap ----
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
      step();
      chk("fullrw.level", if_std.level, D);
      chk("fullrw.ovf",   if_std.overflow, 1'b0);
    end
    chk("fullrw.last_pop", if_std.r_data, 8'h80 + 8'd3);
    for (int i = 0; i < D; i++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      step();
    end

    // ---- Standard mode: A0..A3 then four reads ----
    async_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      step();
      chk("std.seq_data",  if_std.r_data,  8'hA0 + i);
      chk("std.seq_valid", if_std.r_valid, 1'b1);
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    chk("std.seq_rv_low", if_std.r_valid,      1'b0);
    chk("std.seq_empty",  if_std.flag_empty,   1'b1);
    chk("std.seq_ae",     if_std.almost_empty, 1'b1);

    // ---- Empty with simultaneous read/write ----
    drive(1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
    step();
    chk("emptyrw.level", if_std.level,     1);
    chk("emptyrw.udf",   if_std.underflow, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    step();
    chk("emptyrw.udf_clr", if_std.underflow, 1'b0);

    // ---- FWFT fall-through of a single word ----
    async_reset();
    drive(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("fwft.data",  if_fw.r_data,  8'h3C);
    chk("fwft.valid", if_fw.r_valid, 1'b1);
    step();
    chk("fwft.hold", if_fw.r_data, 8'h3C);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    step();
    chk("fwft.pop_valid", if_fw.r_valid,    1'b0);
    chk("fwft.pop_empty", if_fw.flag_empty, 1'b1);

    // ---- Flush beats a concurrent write ----
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 1'b1, 8'hEE, 1'b0, 1'b0);
    step();
    chk("flush.level", if_std.level,      0);
    chk("flush.empty", if_std.flag_empty, 1'b1);
    chk("flush.ovf",   if_std.overflow,   1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    chk("flush.dropped", if_fw.r_valid, 1'b0);

    // ---- Reset mid-burst ----
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 8'(8'h60 + i), i[0], 1'b0);
      step();
    end
    async_reset();
    chk("midrst.level", if_std.level,      0);
    chk("midrst.empty", if_std.flag_empty, 1'b1);

    // ---- Randomised traffic with alternating fill/drain bias ----
    for (int p = 0; p < 12; p++) begin
      for (int i = 0; i < 250; i++) begin
        drive(($urandom_range(0, 99) == 0),
              ($urandom_range(0, 99) < ((p % 2 == 0) ? 80 : 25)),
              8'($urandom),
              ($urandom_range(0, 99) < ((p % 2 == 0) ? 30 : 75)),
              ($urandom_range(0, 31) == 0));
        step();
      end
    end

    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Parametrised synchronous FIFO for USB hub packet/byte buffering between the port PHY-side logic and the hub routing core. It generalises the existing single-mode FIFO with power-of-two depth decoupled from pointer width, an occupancy count, programmable almost-full/almost-empty thresholds, and a selectable standard or first-word-fall-through (FWFT) read mode. It also adds synchronous flush and sticky overflow/underflow error flags. Single clock domain.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
AF_THRESH, 12, almost_full asserted when level >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, almost_empty asserted when level <= AE_THRESH (0..DEPTH-1)
FWFT, 0, 0 = standard read (1-cycle latency), 1 = first-word-fall-through

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of FIFO contents
wr_en  in  1  write request
w_data  in  WIDTH  write data
rd_en  in  1  read request (pop in FWFT mode)
r_data  out  WIDTH  read data
r_valid  out  1  r_data valid
flag_full  out  1  level == DEPTH
flag_empty  out  1  level == 0
almost_full  out  1  level >= AF_THRESH
almost_empty  out  1  level <= AE_THRESH
level  out  AW+1  current occupancy, AW = clog2(DEPTH)
overflow  out  1  sticky: write attempted and rejected
underflow  out  1  sticky: read attempted while empty
clr_err  in  1  synchronous clear of overflow/underflow

Behaviour:
- Reset: one clock clk; reset is asynchronous, active-low (rst_n). While rst_n is low: pointers=0, level=0, r_data=0, r_valid=0, overflow=0, underflow=0, flag_empty=1, flag_full=0, almost_empty=1, almost_full=0. Storage is not cleared.
- Pointers: wr_ptr and rd_ptr are AW bits and wrap naturally from DEPTH-1 to 0. level is a registered AW+1-bit counter.
- All flags are combinational decodes of the registered level, so they are glitch-free and change in the cycle after the causing edge.
- rd_acc = rd_en && !flag_empty.
- wr_acc = wr_en && (!flag_full || rd_acc). When full, a simultaneous read and write are both accepted and level stays at DEPTH.
- When empty, a simultaneous read and write accept the write only. The read is rejected and sets underflow.
- level update: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither.
- Standard mode (FWFT=0): on rd_acc, r_data <= head entry at the next edge and r_valid pulses high for that one cycle. Otherwise r_valid=0 and r_data holds its last value.
- FWFT mode (FWFT=1): r_data continuously presents storage[rd_ptr] and r_valid = !flag_empty. rd_acc advances to the next entry at the edge. A word written into an empty FIFO appears on r_data one cycle after the write edge.
- Errors: overflow sets on wr_en && !wr_acc. underflow sets on rd_en && flag_empty. Both hold until clr_err. If set and clear occur in the same cycle, set wins.
- flush: has priority over wr_en/rd_en in the same cycle. It zeroes pointers and level, and clears r_valid. It does not touch r_data in standard mode or the error flags. No error is flagged for requests dropped by flush.
- Reset mid-operation discards all contents immediately, asynchronously.

Decomposition:
- Shared package usb_fifo_pkg: clog2 function, default WIDTH/DEPTH constants, read-mode encodings (FIFO_STD=0, FIFO_FWFT=1).
- Sub-module fifo_mem: DEPTH x WIDTH register array with one synchronous write port and one asynchronous read port, no reset.
- sync_fifo_ctrl owns the pointers, level, flags, read-mode logic and error logic.

Test Plan:
- Reset, then write 0x01..0x10 (DEPTH=16) -> flag_full=1 and level=16 after the 16th edge. almost_full rises after the 12th write. A 17th wr_en leaves level=16 and sets overflow=1.
- Standard mode: fill 0xA0..0xA3, then rd_en for 4 cycles -> r_data = A0,A1,A2,A3 each one cycle after its rd_en, with r_valid pulsing. Then flag_empty=1 and almost_empty=1 (level<=2).
- Full FIFO with wr_en=rd_en=1 for 20 cycles -> level stays 16, data order is preserved across pointer wrap, and overflow stays 0.
- Empty FIFO with wr_en=rd_en=1 and w_data=0x55 -> level=1 and underflow=1. clr_err next cycle -> underflow=0.
- FWFT=1: write 0x3C into an empty FIFO -> r_data=0x3C and r_valid=1 on the next cycle with no rd_en. rd_en for one cycle -> r_valid=0 and flag_empty=1.
- Fill 8 words, then assert flush together with wr_en -> level=0, flag_empty=1, and the write is dropped. Assert rst_n=0 mid-burst -> all outputs take reset values immediately.
